probe_capture: RTL and testbench
================================

PROBE_CAPTURE -- requirements
Module: probe_capture

Interface
REQ-001 Parameter width, default 1: bit width of the probed value and of each stored sample.
REQ-002 Parameter depth, default 16: capture buffer entries; SHALL be a power of two, minimum 1.
REQ-003 Parameter cntw, default 5: COUNT width; SHALL equal log2(depth)+1.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 IN  input  width  probed value from the upstream probe wire.
REQ-007 ARM  input  1  single-cycle request to arm the capture.
REQ-008 TRIG  input  1  trigger condition, level-sampled each cycle.
REQ-009 CLR  input  1  abort and flush; returns the block to IDLE.
REQ-010 DEQ  input  1  consumer pop request for the head sample.
REQ-011 OUT  output  width  head sample of the buffer; 0 whenever OUT_VALID is 0.
REQ-012 OUT_VALID  output  1  head sample present and readable.
REQ-013 COUNT  output  cntw  number of samples currently held (0..depth).
REQ-014 STATE  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Function
REQ-015 IDLE: ARM=1 SHALL move to ARMED next edge; TRIG and DEQ SHALL be ignored.
REQ-016 ARMED: TRIG=1 SHALL write IN into the buffer on that edge (COUNT becomes 1) and move to CAPTURE, or directly to DONE when depth=1.
REQ-017 CAPTURE: IN SHALL be written every cycle regardless of TRIG; on the edge that writes entry number depth, the state SHALL become DONE.
REQ-018 Exactly depth samples SHALL be stored per capture, in consecutive cycles, with no gaps or duplicates.
REQ-019 DONE: OUT_VALID SHALL be 1 iff COUNT != 0; OUT SHALL show the oldest unread sample, read combinationally from the buffer.
REQ-020 DONE with DEQ=1 and OUT_VALID=1: read pointer SHALL advance and COUNT SHALL decrement on that edge; one pop per cycle maximum.
REQ-021 The pop that takes COUNT from 1 to 0 SHALL also move the state to IDLE on that same edge.
REQ-022 DEQ while OUT_VALID=0 SHALL have no effect; no underflow.
REQ-023 Writes SHALL never occur in DONE or IDLE; the buffer cannot overflow.
REQ-024 Read and write pointers SHALL be log2(depth) bits and wrap modulo depth; both SHALL return to 0 when entering IDLE.
REQ-025 ARM outside IDLE SHALL be ignored; ARM and TRIG together in IDLE SHALL arm only, with no sample taken.
REQ-026 CLR=1 SHALL take priority over ARM, TRIG and DEQ in every state: next edge state=IDLE, COUNT=0, pointers=0, OUT_VALID=0.
REQ-027 OUT_VALID SHALL be 0 in IDLE, ARMED and CAPTURE.

Reset
REQ-028 RST_N=0 SHALL immediately, without waiting for CLK, force STATE=IDLE, COUNT=0, both pointers=0, OUT_VALID=0 and OUT=0, including during CAPTURE or DONE.
REQ-029 Buffer storage SHALL NOT require reset; stale contents SHALL never be visible because OUT is masked.
REQ-030 After RST_N deasserts, the first edge SHALL honour ARM normally.

Verification (width=8, depth=4)
REQ-031 ARM; TRIG at edge with IN=0x10, IN incrementing per cycle -> STATE 1,2,2,2,3, COUNT=4, OUT_VALID=1, OUT=0x10.
REQ-032 From REQ-031, DEQ held high -> OUT 0x10,0x11,0x12,0x13; COUNT 4,3,2,1,0; STATE=0 after the 4th pop; extra DEQ has no effect.
REQ-033 TRIG=1 with no ARM -> STATE stays 0, COUNT=0; ARM and TRIG in the same cycle -> STATE=1, COUNT=0.
REQ-034 CLR at COUNT=2 in CAPTURE -> next edge STATE=0, COUNT=0; CLR and ARM together -> STATE=0.
REQ-035 RST_N pulsed low between edges in DONE with COUNT=3 -> OUT_VALID=0, OUT=0, COUNT=0, STATE=0 before the next edge.
REQ-036 depth=1 build: ARM, then TRIG with IN=0xA5 -> STATE=3, OUT=0xA5; one DEQ -> STATE=0.

Source files
------------

// File: rtl/probe_capture_if.sv
// Probe-capture signal bundle: stimulus/consumer controls toward the capture
// block and the buffered sample/status returned from it.
interface probe_capture_if #(
  parameter int width = 1,
  parameter int cntw  = 5
);
  logic [width-1:0] in;
  logic             arm;
  logic             trig;
  logic             clr;
  logic             deq;
  logic [width-1:0] out;
  logic             out_valid;
  logic [cntw-1:0]  count;
  logic [1:0]       state;

  modport master (
    output in, arm, trig, clr, deq,
    input  out, out_valid, count, state
  );

  modport slave (
    input  in, arm, trig, clr, deq,
    output out, out_valid, count, state
  );
endinterface

// File: rtl/probe_capture.sv
// One-shot logic-analyser capture: arm, wait for a trigger, record depth
// consecutive samples, then let a consumer drain them oldest-first.
module probe_capture #(
  parameter int width = 1,
  parameter int depth = 16,
  parameter int cntw  = 5
) (
  input logic           clk,
  input logic           rst_n,
  probe_capture_if.slave pc
);

  // A depth-1 buffer still gets a 1-bit pointer, held at zero by ptr_inc.
  localparam int ptrw = (depth > 1) ? $clog2(depth) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [cntw-1:0] last_c = cntw'(depth - 1);
  localparam logic [cntw-1:0] one_c  = cntw'(1);

  state_t           state_r;
  state_t           state_s;
  logic [cntw-1:0]  count_r;
  logic [ptrw-1:0]  wr_ptr_r;
  logic [ptrw-1:0]  rd_ptr_r;
  logic [width-1:0] mem_r [depth];
  logic             wr_en_s;
  logic             rd_en_s;
  logic             out_valid_s;
  logic [width-1:0] out_s;

  function automatic logic [ptrw-1:0] ptr_inc(input logic [ptrw-1:0] p);
    if (depth == 1) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + ptrw'(1);
    end
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; clr overrides every other request.
  always_comb begin
    state_s = state_r;
    if (pc.clr) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (pc.arm) state_s = ARMED; else state_s = IDLE;
        ARMED:   if (pc.trig) state_s = (depth == 1) ? DONE : CAPTURE;
                 else state_s = ARMED;
        CAPTURE: if (count_r == last_c) state_s = DONE; else state_s = CAPTURE;
        DONE:    if (rd_en_s && (count_r == one_c)) state_s = IDLE;
                 else state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Output and datapath-enable decode from the current state.
  always_comb begin
    wr_en_s     = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ARMED:   wr_en_s = pc.trig & ~pc.clr;
      CAPTURE: wr_en_s = ~pc.clr;
      DONE:    out_valid_s = (count_r != '0);
      default: wr_en_s = 1'b0;
    endcase
    rd_en_s = out_valid_s & pc.deq & ~pc.clr;
    if (out_valid_s) begin
      out_s = mem_r[rd_ptr_r];
    end else begin
      out_s = '0;
    end
  end

  // Occupancy and pointers; both pointers rewind whenever IDLE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (state_s == IDLE) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (wr_en_s) begin
      count_r  <= count_r + one_c;
      wr_ptr_r <= ptr_inc(wr_ptr_r);
    end else if (rd_en_s) begin
      count_r  <= count_r - one_c;
      rd_ptr_r <= ptr_inc(rd_ptr_r);
    end
  end

  // Sample storage is never reset; out is masked until a capture completes.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= pc.in;
    end
  end

  assign pc.state     = state_r;
  assign pc.count     = count_r;
  assign pc.out_valid = out_valid_s;
  assign pc.out       = out_s;

endmodule

// File: tb/tb_probe_capture.sv
// Directed checks of probe_capture: a width=8/depth=4 instance for the main
// behaviour and a depth=1 instance for the single-entry corner.
module tb_probe_capture;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  probe_capture_if #(.width(8), .cntw(3)) pif ();
  probe_capture_if #(.width(8), .cntw(1)) pif1 ();

  probe_capture #(.width(8), .depth(4), .cntw(3)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pif.slave)
  );

  probe_capture #(.width(8), .depth(1), .cntw(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pc(pif1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pif.in = 8'h00; pif.arm = 1'b0; pif.trig = 1'b0; pif.clr = 1'b0; pif.deq = 1'b0;
    pif1.in = 8'h00; pif1.arm = 1'b0; pif1.trig = 1'b0; pif1.clr = 1'b0; pif1.deq = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (pif.state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", pif.state); end
    vectors++; if (pif.count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", pif.count); end
    vectors++; if (pif.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", pif.out_valid); end
    vectors++; if (pif.out !== 8'h00) begin miscompares++; $display("FAIL reset_out got %h want 00", pif.out); end
    #2 rst_n = 1'b1;
  endtask

  // Arm, trigger at in=base, then keep incrementing in; ends in DONE.
  task automatic fill(input logic [7:0] base, input bit check);
    logic [1:0] exp_state [5];
    exp_state[0] = 2'd1; exp_state[1] = 2'd2; exp_state[2] = 2'd2;
    exp_state[3] = 2'd2; exp_state[4] = 2'd3;
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    if (check) begin
      vectors++; if (pif.state !== exp_state[0]) begin miscompares++; $display("FAIL fill_state0 got %0d want %0d", pif.state, exp_state[0]); end
    end
    for (int i = 0; i < 4; i++) begin
      pif.trig = (i == 0);
      pif.in = base + 8'(i);
      tick();
      if (check) begin
        vectors++; if (pif.state !== exp_state[i+1]) begin miscompares++; $display("FAIL fill_state%0d got %0d want %0d", i + 1, pif.state, exp_state[i+1]); end
        vectors++; if (pif.count !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count%0d got %0d want %0d", i + 1, pif.count, i + 1); end
      end
    end
    pif.trig = 1'b0;
    pif.in = 8'hEE;
  endtask

  task automatic test_capture();
    fill(8'h10, 1'b1);
    tick();
    vectors++; if (pif.state !== 2'd3) begin miscompares++; $display("FAIL done_hold_state got %0d want 3", pif.state); end
    vectors++; if (pif.out_valid !== 1'b1) begin miscompares++; $display("FAIL done_valid got %b want 1", pif.out_valid); end
    vectors++; if (pif.out !== 8'h10) begin miscompares++; $display("FAIL done_out got %h want 10", pif.out); end
  endtask

  task automatic test_drain();
    pif.deq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pif.out !== 8'h10 + 8'(i)) begin miscompares++; $display("FAIL drain_out%0d got %h want %h", i, pif.out, 8'h10 + 8'(i)); end
      vectors++; if (pif.count !== 3'(4 - i)) begin miscompares++; $display("FAIL drain_count%0d got %0d want %0d", i, pif.count, 4 - i); end
      tick();
    end
    vectors++; if (pif.state !== 2'd0) begin miscompares++; $display("FAIL drain_state got %0d want 0", pif.state); end
    vectors++; if (pif.count !== 3'd0) begin miscompares++; $display("FAIL drain_count_end got %0d want 0", pif.count); end
    tick();
    vectors++; if (pif.count !== 3'd0) begin miscompares++; $display("FAIL extra_deq_count got %0d want 0", pif.count); end
    vectors++; if (pif.out_valid !== 1'b0 || pif.out !== 8'h00) begin miscompares++; $display("FAIL extra_deq_out got %b/%h want 0/00", pif.out_valid, pif.out); end
    pif.deq = 1'b0;
  endtask

  task automatic test_trigger_gating();
    pif.trig = 1'b1;
    tick();
    vectors++; if (pif.state !== 2'd0 || pif.count !== 3'd0) begin miscompares++; $display("FAIL trig_idle got %0d/%0d want 0/0", pif.state, pif.count); end
    pif.arm = 1'b1;
    tick();
    vectors++; if (pif.state !== 2'd1 || pif.count !== 3'd0) begin miscompares++; $display("FAIL arm_trig got %0d/%0d want 1/0", pif.state, pif.count); end
    pif.arm = 1'b0; pif.trig = 1'b0;
    tick();
    vectors++; if (pif.state !== 2'd1) begin miscompares++; $display("FAIL armed_wait got %0d want 1", pif.state); end
    pif.clr = 1'b1;
    tick();
    pif.clr = 1'b0;
    vectors++; if (pif.state !== 2'd0) begin miscompares++; $display("FAIL clr_armed got %0d want 0", pif.state); end
  endtask

  task automatic test_clear();
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b1; pif.trig = 1'b1; pif.in = 8'h20;
    tick();
    pif.arm = 1'b1; pif.trig = 1'b0; pif.in = 8'h21;
    tick();
    vectors++; if (pif.state !== 2'd2 || pif.count !== 3'd2) begin miscompares++; $display("FAIL arm_in_capture got %0d/%0d want 2/2", pif.state, pif.count); end
    pif.arm = 1'b0; pif.clr = 1'b1;
    tick();
    vectors++; if (pif.state !== 2'd0 || pif.count !== 3'd0) begin miscompares++; $display("FAIL clr_capture got %0d/%0d want 0/0", pif.state, pif.count); end
    pif.arm = 1'b1;
    tick();
    vectors++; if (pif.state !== 2'd0) begin miscompares++; $display("FAIL clr_arm got %0d want 0", pif.state); end
    pif.arm = 1'b0; pif.clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    fill(8'h30, 1'b0);
    pif.deq = 1'b1;
    tick();
    pif.deq = 1'b0;
    vectors++; if (pif.out !== 8'h31 || pif.count !== 3'd3) begin miscompares++; $display("FAIL refill_head got %h/%0d want 31/3", pif.out, pif.count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pif.out_valid !== 1'b0 || pif.out !== 8'h00) begin miscompares++; $display("FAIL async_rst_out got %b/%h want 0/00", pif.out_valid, pif.out); end
    vectors++; if (pif.count !== 3'd0 || pif.state !== 2'd0) begin miscompares++; $display("FAIL async_rst_state got %0d/%0d want 0/0", pif.count, pif.state); end
    #1 rst_n = 1'b1;
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    vectors++; if (pif.state !== 2'd1) begin miscompares++; $display("FAIL arm_after_rst got %0d want 1", pif.state); end
    pif.clr = 1'b1;
    tick();
    pif.clr = 1'b0;
  endtask

  task automatic test_depth1();
    pif1.arm = 1'b1;
    tick();
    pif1.arm = 1'b0;
    vectors++; if (pif1.state !== 2'd1) begin miscompares++; $display("FAIL d1_armed got %0d want 1", pif1.state); end
    pif1.trig = 1'b1; pif1.in = 8'hA5;
    tick();
    pif1.trig = 1'b0; pif1.in = 8'h5A;
    vectors++; if (pif1.state !== 2'd3 || pif1.count !== 1'b1) begin miscompares++; $display("FAIL d1_done got %0d/%0d want 3/1", pif1.state, pif1.count); end
    vectors++; if (pif1.out !== 8'hA5 || pif1.out_valid !== 1'b1) begin miscompares++; $display("FAIL d1_out got %h/%b want a5/1", pif1.out, pif1.out_valid); end
    tick();
    vectors++; if (pif1.out !== 8'hA5) begin miscompares++; $display("FAIL d1_hold got %h want a5", pif1.out); end
    pif1.deq = 1'b1;
    tick();
    pif1.deq = 1'b0;
    vectors++; if (pif1.state !== 2'd0 || pif1.out_valid !== 1'b0) begin miscompares++; $display("FAIL d1_pop got %0d/%b want 0/0", pif1.state, pif1.out_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_capture();
    test_drain();
    test_trigger_gating();
    test_clear();
    test_back_to_back();
    test_depth1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
